// File: rtl/segment_scan_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : seg_scan_pkg                                               |
// | Brief   : Segment codes, BCD specials and FSM states shared by the   |
// |           7-segment scan decoder and its sub-module.                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package seg_scan_pkg;

  // Active-low segment codes, bit order dp-G-F-E-D-C-B-A (dp unlit)
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_DP  = 8'h7F;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Nibble values reported for the two non-numeric legal patterns
  localparam logic [3:0] BCD_DP    = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Scan FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/segment_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : segment_scan_decoder_if                                  |
// | Brief     : Display bus (anodes + segments) and decoded results.     |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface segment_scan_decoder_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg_data;
  logic [4*DIGITS-1:0] digits_bcd;
  logic [DIGITS-1:0]   dp_flags;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                err_pattern;
  logic                err_anode;

  // Display driver side: drives the bus, observes decoded results
  modport master (
    output an, seg_data,
    input  digits_bcd, dp_flags, digit_valid, frame_done, err_pattern, err_anode
  );

  // Decoder side
  modport slave (
    input  an, seg_data,
    output digits_bcd, dp_flags, digit_valid, frame_done, err_pattern, err_anode
  );
endinterface
`default_nettype wire

// File: rtl/segment_scan_decoder_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : segment_to_bcd                                              |
// | Brief  : Inverts the active-low G..A segment pattern to a BCD digit. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module segment_to_bcd
  import seg_scan_pkg::*;
(
  input  wire logic [6:0] i_seg,
  output logic            o_legal,
  output logic [3:0]      o_bcd
);

  // Pattern lookup; anything not a digit 0-9 is flagged illegal
  always_comb begin
    o_legal = 1'b1;
    o_bcd   = 4'h0;
    case (i_seg)
      SEG_0[6:0]: o_bcd = 4'd0;
      SEG_1[6:0]: o_bcd = 4'd1;
      SEG_2[6:0]: o_bcd = 4'd2;
      SEG_3[6:0]: o_bcd = 4'd3;
      SEG_4[6:0]: o_bcd = 4'd4;
      SEG_5[6:0]: o_bcd = 4'd5;
      SEG_6[6:0]: o_bcd = 4'd6;
      SEG_7[6:0]: o_bcd = 4'd7;
      SEG_8[6:0]: o_bcd = 4'd8;
      SEG_9[6:0]: o_bcd = 4'd9;
      default:    o_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/segment_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : segment_scan_decoder                                        |
// | Brief  : Samples a multiplexed 7-segment bus, waits for each digit   |
// |          dwell to settle and captures BCD + dp per digit.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module segment_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int STABLE_CNT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  segment_scan_decoder_if.slave  bus
);

  localparam int                CW        = $clog2(STABLE_CNT);
  localparam logic [CW-1:0]     C_CNT_MAX = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0]     C_CNT_ONE = CW'(1);
  localparam logic [DIGITS-1:0] C_ONE     = DIGITS'(1);

  logic [DIGITS-1:0]   r_an_q, r_an_prev;
  logic [7:0]          r_seg_q, r_seg_prev;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_state, w_state_nxt;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_dp, r_valid, r_seen;
  logic                r_frame_done, r_err_pattern, r_err_anode;

  logic                w_change, w_blank_an, w_multi, w_onehot, w_capture;
  logic [DIGITS-1:0]   w_low, w_seen_nxt;
  logic                w_dec_legal, w_cap_legal, w_cap_dp;
  logic [3:0]          w_dec_bcd, w_cap_nib;

  segment_to_bcd u_to_bcd (
    .i_seg   (r_seg_q[6:0]),
    .o_legal (w_dec_legal),
    .o_bcd   (w_dec_bcd)
  );

  assign w_change   = (r_an_q != r_an_prev) || (r_seg_q != r_seg_prev);
  assign w_blank_an = &r_an_q;
  assign w_low      = ~r_an_q;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign w_multi    = |(w_low & (w_low - C_ONE));
  assign w_onehot   = (|w_low) && !w_multi;
  // The saturated count describes the previous samples; a change this cycle voids it
  assign w_capture  = (r_state == ST_TRACK) && !w_change && (r_cnt == C_CNT_MAX) && !w_blank_an;
  assign w_seen_nxt = r_seen | w_low;

  // Resolve the captured value, including the dp-only and blank specials
  always_comb begin
    w_cap_legal = w_dec_legal;
    w_cap_nib   = w_dec_bcd;
    w_cap_dp    = ~r_seg_q[7];
    if (r_seg_q == SEG_DP) begin
      w_cap_legal = 1'b1;
      w_cap_nib   = BCD_DP;
      w_cap_dp    = 1'b1;
    end else if (r_seg_q == SEG_OFF) begin
      w_cap_legal = 1'b1;
      w_cap_nib   = BCD_BLANK;
      w_cap_dp    = 1'b0;
    end
  end

  // Input registers, one-cycle history and saturating stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an_q     <= '1;
      r_an_prev  <= '1;
      r_seg_q    <= SEG_OFF;
      r_seg_prev <= SEG_OFF;
      r_cnt      <= '0;
    end else begin
      r_an_q     <= bus.an;
      r_seg_q    <= bus.seg_data;
      r_an_prev  <= r_an_q;
      r_seg_prev <= r_seg_q;
      if (w_change)
        r_cnt <= '0;
      else if (r_cnt != C_CNT_MAX)
        r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  // Next-state logic: one capture per dwell, blank anodes park in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_change && !w_blank_an) w_state_nxt = ST_TRACK;
      ST_TRACK: if (w_change)                w_state_nxt = w_blank_an ? ST_IDLE : ST_TRACK;
                else if (w_capture)          w_state_nxt = ST_DONE;
      ST_DONE:  if (w_change)                w_state_nxt = w_blank_an ? ST_IDLE : ST_TRACK;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture action: per-digit storage, frame tracking and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd         <= '1;
      r_dp          <= '0;
      r_valid       <= '0;
      r_seen        <= '0;
      r_frame_done  <= 1'b0;
      r_err_pattern <= 1'b0;
      r_err_anode   <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_err_pattern <= 1'b0;
      r_err_anode   <= 1'b0;
      if (w_capture) begin
        if (w_multi) begin
          r_err_anode <= 1'b1;
        end else if (w_onehot) begin
          if (w_cap_legal) begin
            for (int i = 0; i < DIGITS; i++)
              if (w_low[i]) r_bcd[4*i +: 4] <= w_cap_nib;
            r_dp    <= (r_dp & ~w_low) | (w_low & {DIGITS{w_cap_dp}});
            r_valid <= r_valid | w_low;
            if (&w_seen_nxt) begin
              r_frame_done <= 1'b1;
              r_seen       <= '0;
            end else begin
              r_seen <= w_seen_nxt;
            end
          end else begin
            r_err_pattern <= 1'b1;
            r_valid       <= r_valid & ~w_low;
          end
        end
      end
    end
  end

  assign bus.digits_bcd  = r_bcd;
  assign bus.dp_flags    = r_dp;
  assign bus.digit_valid = r_valid;
  assign bus.frame_done  = r_frame_done;
  assign bus.err_pattern = r_err_pattern;
  assign bus.err_anode   = r_err_anode;

endmodule
`default_nettype wire

// File: tb/tb_segment_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_segment_scan_decoder                                     |
// | Brief  : Self-checking bench for segment_scan_decoder (8 digits,     |
// |          4-sample stability) with a dwell-based reference model.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_segment_scan_decoder;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  segment_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  segment_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (dwell-based) ----------------
  logic [3:0] m_nib [DIGITS];
  logic [7:0] m_dp, m_valid, m_seen;
  logic [7:0] last_an, last_seg, pend_an, pend_seg;
  int         run;
  bit         pend, e_frame, e_errp, e_erra;
  int         n_frame, n_errp, n_erra;

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'hF;
    m_dp = '0; m_valid = '0; m_seen = '0;
    last_an = 8'hFF; last_seg = 8'hFF; run = 0; pend = 0;
    e_frame = 0; e_errp = 0; e_erra = 0;
  endtask

  task automatic model_capture(input logic [7:0] an, input logic [7:0] seg);
    int nz = 0, idx = 0;
    bit ok = 0, dp = 0;
    logic [3:0] nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) begin nz++; idx = i; end
    if (nz > 1) begin
      e_erra = 1;
    end else if (nz == 1) begin
      if (seg == 8'h7F) begin ok = 1; nib = 4'hA; dp = 1; end
      else if (seg == 8'hFF) begin ok = 1; nib = 4'hF; dp = 0; end
      else for (int k = 0; k < 10; k++)
        if (seg[6:0] == seg_code(k)) begin ok = 1; nib = 4'(k); dp = !seg[7]; end
      if (ok) begin
        m_nib[idx] = nib; m_dp[idx] = dp; m_valid[idx] = 1'b1; m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin e_frame = 1; m_seen = '0; end
      end else begin
        e_errp = 1; m_valid[idx] = 1'b0;
      end
    end
  endtask

  // A value sampled on STABLE+1 consecutive edges is captured once, visible one edge later
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_frame = 0; e_errp = 0; e_erra = 0;
    if (pend) model_capture(pend_an, pend_seg);
    pend = 0;
    if (bus.an == last_an && bus.seg_data == last_seg) begin
      if (run < 1000) run++;
    end else begin
      run = 1; last_an = bus.an; last_seg = bus.seg_data;
    end
    if (run == STABLE + 1 && bus.an != 8'hFF) begin
      pend = 1; pend_an = bus.an; pend_seg = bus.seg_data;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] eb;
    @(posedge clk);
    model_edge();
    #1;
    n_frame += int'(bus.frame_done);
    n_errp  += int'(bus.err_pattern);
    n_erra  += int'(bus.err_anode);
    for (int i = 0; i < DIGITS; i++) eb[4*i +: 4] = m_nib[i];
    total++;
    if (bus.digits_bcd !== eb || bus.dp_flags !== m_dp || bus.digit_valid !== m_valid ||
        bus.frame_done !== e_frame || bus.err_pattern !== e_errp || bus.err_anode !== e_erra) begin
      bad++;
      $display("FAIL model t=%0t: got bcd=%h dp=%h v=%h f=%b ep=%b ea=%b expected bcd=%h dp=%h v=%h f=%b ep=%b ea=%b",
               $time, bus.digits_bcd, bus.dp_flags, bus.digit_valid, bus.frame_done,
               bus.err_pattern, bus.err_anode, eb, m_dp, m_valid, e_frame, e_errp, e_erra);
    end
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    bus.an = an; bus.seg_data = seg;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    n_frame = 0; n_errp = 0; n_erra = 0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    int         idx;    // digit to inspect; DIGITS means "nothing may change"
    logic [3:0] nib;
    logic       dp;
    logic       valid;
    int         nf;
    int         nep;
    int         nea;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] snap_bcd;
    logic [7:0]  snap_dp, snap_v;
    logic [7:0]  an;
    logic [7:0]  seg;
    int          r;

    vecs[0]  = '{8'hFE, 8'hF9, 0, 4'h1, 1'b0, 1'b1, 0, 0, 0};
    vecs[1]  = '{8'hFD, 8'hA4, 1, 4'h2, 1'b0, 1'b1, 0, 0, 0};
    vecs[2]  = '{8'hFB, 8'h40, 2, 4'h0, 1'b1, 1'b1, 0, 0, 0};
    vecs[3]  = '{8'hF7, 8'hB0, 3, 4'h3, 1'b0, 1'b1, 0, 0, 0};
    vecs[4]  = '{8'hEF, 8'h99, 4, 4'h4, 1'b0, 1'b1, 0, 0, 0};
    vecs[5]  = '{8'hDF, 8'h40, 5, 4'h0, 1'b1, 1'b1, 0, 0, 0};
    vecs[6]  = '{8'hBF, 8'h92, 6, 4'h5, 1'b0, 1'b1, 0, 0, 0};
    vecs[7]  = '{8'h7F, 8'h82, 7, 4'h6, 1'b0, 1'b1, 1, 0, 0};
    vecs[8]  = '{8'hFE, 8'h7F, 0, 4'hA, 1'b1, 1'b1, 0, 0, 0};
    vecs[9]  = '{8'hFD, 8'hFF, 1, 4'hF, 1'b0, 1'b1, 0, 0, 0};
    vecs[10] = '{8'hFB, 8'h55, 2, 4'h0, 1'b1, 1'b0, 0, 1, 0};
    vecs[11] = '{8'hFC, 8'hC0, DIGITS, 4'h0, 1'b0, 1'b0, 0, 0, 1};

    model_reset();
    clear_counts();
    rst_n = 1'b0;
    bus.an = 8'hFF;
    bus.seg_data = 8'hFF;

    // Reset values
    repeat (2) tick();
    check("reset_bcd",   bus.digits_bcd, 32'hFFFFFFFF);
    check("reset_dp",    32'(bus.dp_flags), 32'h0);
    check("reset_valid", 32'(bus.digit_valid), 32'h0);
    check("reset_pulse", {29'd0, bus.frame_done, bus.err_pattern, bus.err_anode}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Capture latency: visible on the sixth edge after the new value is driven
    bus.an = 8'hFE; bus.seg_data = 8'hA4;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("latency_valid0_e%0d", k), 32'(bus.digit_valid[0]), (k == 6) ? 32'd1 : 32'd0);
    end
    check("latency_nib0", 32'(bus.digits_bcd[3:0]), 32'h2);
    check("latency_dp0",  32'(bus.dp_flags[0]), 32'h0);

    // Table: full scan, special patterns, and both error kinds
    for (int v = 0; v < 12; v++) begin
      snap_bcd = bus.digits_bcd; snap_dp = bus.dp_flags; snap_v = bus.digit_valid;
      clear_counts();
      hold(vecs[v].an, vecs[v].seg, 8);
      check($sformatf("v%0d_frame", v), 32'(n_frame), 32'(vecs[v].nf));
      check($sformatf("v%0d_errpat", v), 32'(n_errp), 32'(vecs[v].nep));
      check($sformatf("v%0d_erranode", v), 32'(n_erra), 32'(vecs[v].nea));
      if (vecs[v].idx < DIGITS) begin
        check($sformatf("v%0d_nib", v), 32'(bus.digits_bcd[4*vecs[v].idx +: 4]), 32'(vecs[v].nib));
        check($sformatf("v%0d_dp", v), 32'(bus.dp_flags[vecs[v].idx]), 32'(vecs[v].dp));
        check($sformatf("v%0d_valid", v), 32'(bus.digit_valid[vecs[v].idx]), 32'(vecs[v].valid));
      end else begin
        check($sformatf("v%0d_bcd_kept", v), bus.digits_bcd, snap_bcd);
        check($sformatf("v%0d_dp_kept", v), 32'(bus.dp_flags), 32'(snap_dp));
        check($sformatf("v%0d_valid_kept", v), 32'(bus.digit_valid), 32'(snap_v));
      end
    end

    // Glitch shorter than the stability window inside a steady dwell
    hold(8'hFD, 8'hF9, 8);
    clear_counts();
    bus.seg_data = 8'h92;
    repeat (2) tick();
    bus.seg_data = 8'hF9;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("glitch_nib1_c%0d", k), 32'(bus.digits_bcd[7:4]), 32'h1);
    end
    check("glitch_errpat",   32'(n_errp), 32'h0);
    check("glitch_erranode", 32'(n_erra), 32'h0);
    check("glitch_valid1",   32'(bus.digit_valid[1]), 32'h1);

    // Randomized dwells against the model
    for (int s = 0; s < 150; s++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6)      an = ~(8'd1 << $urandom_range(0, 7));
      else if (r == 7) an = 8'hFF;
      else if (r == 8) an = 8'($urandom);
      else             an = ~((8'd1 << $urandom_range(0, 3)) | (8'd16 << $urandom_range(0, 3)));
      r = int'($urandom_range(0, 9));
      if (r <= 5)      seg = {1'($urandom_range(0, 1)), seg_code(int'($urandom_range(0, 9)))};
      else if (r == 6) seg = 8'h7F;
      else if (r == 7) seg = 8'hFF;
      else             seg = 8'($urandom);
      hold(an, seg, int'($urandom_range(1, 8)));
    end

    // Reset in the middle of a dwell, counter at 2
    hold(8'hFE, 8'hC0, 8);
    hold(8'hF7, 8'hB0, 4);
    rst_n = 1'b0;
    tick();
    check("midrst_bcd",   bus.digits_bcd, 32'hFFFFFFFF);
    check("midrst_dp",    32'(bus.dp_flags), 32'h0);
    check("midrst_valid", 32'(bus.digit_valid), 32'h0);
    check("midrst_pulse", {29'd0, bus.frame_done, bus.err_pattern, bus.err_anode}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_nocap", 32'(bus.digit_valid), 32'h0);
    hold(8'hFF, 8'hFF, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
